// File: rtl/mutex_pkg.sv
// Shared types and the per-process protocol step for the three-process mutex model.
package mutex_pkg;

    localparam int unsigned NPROC = 3;
    localparam int unsigned SW    = 2;

    typedef enum logic [SW-1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        CRIT = 2'd2,
        EXIT = 2'd3
    } state_t;

    // win is only asserted when this process is the granted TRY process and the lock is free
    function automatic state_t step_state(state_t s, logic en, logic win);
        state_t n;
        n = s;
        if (en) begin
            unique case (s)
                IDLE:    n = TRY;
                TRY:     n = win ? CRIT : TRY;
                CRIT:    n = EXIT;
                EXIT:    n = IDLE;
                default: n = IDLE;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/mutex_if.sv
// Step-enable bundle driven into the mutex model, one bit per process.
interface mutex_if
    import mutex_pkg::*;
();
    logic [NPROC-1:0] en_a;

    modport master (output en_a);
    modport slave  (input  en_a);
endinterface

// File: rtl/mutex_proc.sv
// One protocol process: computes its next state and whether it takes or frees the lock.
module mutex_proc
    import mutex_pkg::*;
(
    input  logic   en,
    input  state_t state,
    input  logic   grant,
    input  logic   x,
    output state_t next_state,
    output logic   acq,
    output logic   rel
);

    logic win;

    assign win        = grant & x;
    assign next_state = step_state(state, en, win);
    assign acq        = en & (state == TRY) & win;
    assign rel        = en & (state == EXIT);

endmodule

// File: rtl/mutex_system.sv
// Three-process mutual-exclusion model with a shared lock bit and fixed-priority grant.
// Define MUTEX_ASSERT_EN to compile in the lock/ownership invariant checks.
module mutex_system
    import mutex_pkg::*;
(
    input logic   clock,
    input logic   reset,
    mutex_if.slave io
);

    state_t n_reg_0;
    state_t n_reg_1;
    state_t n_reg_2;
    logic   x_reg;

    state_t           cur [NPROC];
    state_t           nxt [NPROC];
    logic [NPROC-1:0] trying;
    logic [NPROC-1:0] grant;
    logic [NPROC-1:0] acq;
    logic [NPROC-1:0] rel;
    logic             x_next;

    assign cur[0] = n_reg_0;
    assign cur[1] = n_reg_1;
    assign cur[2] = n_reg_2;

    always_comb begin
        for (int unsigned i = 0; i < NPROC; i++) begin
            trying[i] = io.en_a[i] & (cur[i] == TRY);
        end
    end

    // Lowest-index enabled TRY process wins, and only against the current lock value
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        if (x_reg) begin
            for (int unsigned i = 0; i < NPROC; i++) begin
                if (trying[i] && !found) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NPROC; g++) begin : g_proc
        mutex_proc u_proc (
            .en         (io.en_a[g]),
            .state      (cur[g]),
            .grant      (grant[g]),
            .x          (x_reg),
            .next_state (nxt[g]),
            .acq        (acq[g]),
            .rel        (rel[g])
        );
    end

    // Release and acquire are mutually exclusive because x_reg=1 means nobody holds the lock
    always_comb begin
        x_next = x_reg;
        if (|rel) begin
            x_next = 1'b1;
        end else if (|acq) begin
            x_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            n_reg_0 <= IDLE;
            n_reg_1 <= IDLE;
            n_reg_2 <= IDLE;
            x_reg   <= 1'b1;
        end else begin
            n_reg_0 <= nxt[0];
            n_reg_1 <= nxt[1];
            n_reg_2 <= nxt[2];
            x_reg   <= x_next;
        end
    end

`ifdef MUTEX_ASSERT_EN
    logic [NPROC-1:0] in_crit;
    logic [NPROC-1:0] owns;

    always_comb begin
        for (int unsigned i = 0; i < NPROC; i++) begin
            in_crit[i] = (cur[i] == CRIT);
            owns[i]    = (cur[i] == CRIT) | (cur[i] == EXIT);
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            assert ($countones(in_crit) <= 1)
                else $error("mutex: more than one process in CRIT");
            assert ($countones(owns) <= 1)
                else $error("mutex: more than one lock owner");
            assert (x_reg == (owns == '0))
                else $error("mutex: lock bit inconsistent with ownership");
        end
    end
`endif

endmodule

// File: tb/tb_mutex_system.sv
// Self-checking bench: directed protocol scenarios plus random enables against a lock model.
module tb_mutex_system;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    // Reference model: per-process protocol phase 0..3 and lock-free flag
    int   m_n [3];
    bit   m_x;

    mutex_if io ();

    mutex_system dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] dut_vec();
        return {dut.n_reg_2, dut.n_reg_1, dut.n_reg_0, dut.x_reg};
    endfunction

    function automatic logic [6:0] model_vec();
        logic [1:0] a, b, c;
        a = m_n[0][1:0];
        b = m_n[1][1:0];
        c = m_n[2][1:0];
        return {c, b, a, m_x};
    endfunction

    // Advance the model by one step using the protocol rules, then clock the DUT
    task automatic tick(input logic rst, input logic [2:0] en);
        int  winner;
        bit  freed;
        int  nn [3];
        reset   = rst;
        io.en_a = en;
        if (rst) begin
            for (int i = 0; i < 3; i++) nn[i] = 0;
            m_x = 1'b1;
        end else begin
            winner = -1;
            freed  = 1'b0;
            if (m_x) begin
                for (int i = 0; i < 3; i++)
                    if (en[i] && m_n[i] == 1 && winner < 0) winner = i;
            end
            for (int i = 0; i < 3; i++) begin
                nn[i] = m_n[i];
                if (en[i]) begin
                    if (m_n[i] == 0)      nn[i] = 1;
                    else if (m_n[i] == 1) nn[i] = (i == winner) ? 2 : 1;
                    else if (m_n[i] == 2) nn[i] = 3;
                    else begin
                        nn[i] = 0;
                        freed = 1'b1;
                    end
                end
            end
            if (freed)           m_x = 1'b1;
            else if (winner >= 0) m_x = 1'b0;
        end
        for (int i = 0; i < 3; i++) m_n[i] = nn[i];
        @(posedge clock);
        #1;
        reset   = 1'b0;
        io.en_a = 3'b000;
    endtask

    task automatic test_reset();
        tick(1'b1, 3'b111);
        total++;
        if (dut_vec() !== 7'b00_00_00_1) begin
            $display("FAIL reset_state got=%b want=%b", dut_vec(), 7'b00_00_00_1);
            bad++;
        end
        tick(1'b0, 3'b000);
        tick(1'b0, 3'b000);
        total++;
        if (dut_vec() !== 7'b00_00_00_1) begin
            $display("FAIL idle_hold got=%b want=%b", dut_vec(), 7'b00_00_00_1);
            bad++;
        end
    endtask

    task automatic test_single_acquire();
        tick(1'b0, 3'b010);
        total++;
        if (dut.n_reg_1 !== 2'd1 || dut.x_reg !== 1'b1) begin
            $display("FAIL p1_try got n1=%0d x=%b want n1=1 x=1", dut.n_reg_1, dut.x_reg);
            bad++;
        end
        tick(1'b0, 3'b010);
        total++;
        if (dut.n_reg_1 !== 2'd2 || dut.x_reg !== 1'b0) begin
            $display("FAIL p1_crit got n1=%0d x=%b want n1=2 x=0", dut.n_reg_1, dut.x_reg);
            bad++;
        end
    endtask

    task automatic test_contention();
        tick(1'b0, 3'b100);
        total++;
        if (dut.n_reg_2 !== 2'd1) begin
            $display("FAIL p2_try got=%0d want=1", dut.n_reg_2);
            bad++;
        end
        tick(1'b0, 3'b100);
        total++;
        if (dut.n_reg_2 !== 2'd1 || dut.x_reg !== 1'b0) begin
            $display("FAIL p2_blocked got n2=%0d x=%b want n2=1 x=0", dut.n_reg_2, dut.x_reg);
            bad++;
        end
        tick(1'b0, 3'b010);
        total++;
        if (dut.n_reg_1 !== 2'd3 || dut.x_reg !== 1'b0) begin
            $display("FAIL p1_exit got n1=%0d x=%b want n1=3 x=0", dut.n_reg_1, dut.x_reg);
            bad++;
        end
        tick(1'b0, 3'b010);
        total++;
        if (dut.n_reg_1 !== 2'd0 || dut.x_reg !== 1'b1 || dut.n_reg_2 !== 2'd1) begin
            $display("FAIL p1_release got n1=%0d n2=%0d x=%b want n1=0 n2=1 x=1",
                     dut.n_reg_1, dut.n_reg_2, dut.x_reg);
            bad++;
        end
        tick(1'b0, 3'b100);
        total++;
        if (dut.n_reg_2 !== 2'd2 || dut.x_reg !== 1'b0) begin
            $display("FAIL p2_crit got n2=%0d x=%b want n2=2 x=0", dut.n_reg_2, dut.x_reg);
            bad++;
        end
    endtask

    task automatic test_all_try();
        tick(1'b1, 3'b000);
        tick(1'b0, 3'b111);
        total++;
        if (dut_vec() !== 7'b01_01_01_1) begin
            $display("FAIL all_try got=%b want=%b", dut_vec(), 7'b01_01_01_1);
            bad++;
        end
        tick(1'b0, 3'b111);
        total++;
        if (dut_vec() !== 7'b01_01_10_0) begin
            $display("FAIL priority_grant got=%b want=%b", dut_vec(), 7'b01_01_10_0);
            bad++;
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 3'b111);
        total++;
        if (dut_vec() !== 7'b00_00_00_1) begin
            $display("FAIL reset_abort got=%b want=%b", dut_vec(), 7'b00_00_00_1);
            bad++;
        end
    endtask

    task automatic test_random();
        int ncrit;
        tick(1'b1, 3'b000);
        for (int c = 0; c < 1000; c++) begin
            tick(($urandom_range(0, 99) == 0), 3'($urandom_range(0, 7)));
            total++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL random_state cyc=%0d got=%b want=%b", c, dut_vec(), model_vec());
                bad++;
            end
            ncrit = 0;
            if (dut.n_reg_0 == 2'd2) ncrit++;
            if (dut.n_reg_1 == 2'd2) ncrit++;
            if (dut.n_reg_2 == 2'd2) ncrit++;
            total++;
            if (ncrit > 1) begin
                $display("FAIL random_excl cyc=%0d crit_count=%0d want<=1", c, ncrit);
                bad++;
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        io.en_a = 3'b000;
        for (int i = 0; i < 3; i++) m_n[i] = 0;
        m_x = 1'b1;
        @(negedge clock);
        test_reset();
        test_single_acquire();
        test_contention();
        test_all_try();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
